seq_divider: RTL

- Sequential radix-2 restoring divider; the inverse companion to the team's Booth shift-add multiplier.
- Takes a DW-bit dividend and a VW-bit divisor. Produces a DW-bit quotient and a VW-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake.
- Control FSM and datapath registers live inside this one module.

---
 rtl/seq_divider.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential radix-2 restoring divider, one quotient bit per clock.
//
// Optional build macro: SEQ_DIVIDER_SIGNED_EN
//   Defined   - operands are two's complement; truncating division; ovf flags the
//               most-negative / -1 case.
//   Undefined - unsigned only; ovf is tied to 0 and no sign logic is built.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   start      division request, sampled only while not busy (IDLE or DONE)
//   dividend   DW-bit operand, captured on the accepting edge
//   divisor    VW-bit operand, captured on the accepting edge
//   busy       high in LOAD and RUN
//   done       single-cycle pulse; results valid from this cycle on
//   quotient   DW-bit result register
//   remainder  VW-bit result register
//   div0       last operation had divisor == 0
//   ovf        signed overflow (signed build only, else 0)
module seq_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0,
  output logic          ovf
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   dividend_q, dividend_d;
  logic [VW-1:0]   divisor_q, divisor_d;
  logic [VW:0]     pr_q, pr_d;
  logic [DW-1:0]   q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   quotient_q, quotient_d;
  logic [VW-1:0]   remainder_q, remainder_d;
  logic            div0_q, div0_d;

  logic            accept;
  logic            divisor_zero;
  logic            last_iter;
  logic [DW-1:0]   dvd_mag;
  logic [VW-1:0]   dvs_mag;
  logic [VW+1:0]   pr_sh;
  logic [VW+1:0]   trial;
  logic            trial_neg;
  logic [VW:0]     pr_next;
  logic [DW-1:0]   q_next;

  assign accept       = start && ((state_q == StIdle) || (state_q == StDone));
  assign divisor_zero = (divisor_q == '0);
  assign last_iter    = (cnt_q == CW'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic ovf_q, ovf_d;
  logic dvd_neg, dvs_neg;
  assign dvd_neg = dividend_q[DW-1];
  assign dvs_neg = divisor_q[VW-1];
  // Most-negative dividend still fits as an unsigned DW-bit magnitude.
  assign dvd_mag = dvd_neg ? (DW'(0) - dividend_q) : dividend_q;
  assign dvs_mag = dvs_neg ? (VW'(0) - divisor_q) : divisor_q;
`else
  assign dvd_mag = dividend_q;
  assign dvs_mag = divisor_q;
`endif

  // One restoring step: shift {PR,Q} left, trial-subtract the divisor magnitude.
  assign pr_sh     = {pr_q, q_q[DW-1]};
  assign trial     = pr_sh - {2'b00, dvs_mag};
  assign trial_neg = trial[VW+1];
  assign pr_next   = trial_neg ? pr_sh[VW:0] : trial[VW:0];
  assign q_next    = {q_q[DW-2:0], ~trial_neg};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = divisor_zero ? StDone : StRun;
      StRun:  if (last_iter) state_d = StDone;
      StDone: state_d = start ? StLoad : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StLoad) || (state_q == StRun);
    done = (state_q == StDone);
  end

  // Datapath next-state
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    pr_d        = pr_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    ovf_d       = ovf_q;
`endif

    if (accept) begin
      dividend_d = dividend;
      divisor_d  = divisor;
      div0_d     = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      ovf_d      = 1'b0;
`endif
    end

    unique case (state_q)
      StLoad: begin
        pr_d  = '0;
        q_d   = dvd_mag;
        cnt_d = CW'(DW);
        if (divisor_zero) begin
          // Raw dividend bits, regardless of signedness.
          quotient_d  = '1;
          remainder_d = dividend_q[VW-1:0];
          div0_d      = 1'b1;
        end
      end
      StRun: begin
        pr_d  = pr_next;
        q_d   = q_next;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          quotient_d  = (dvd_neg ^ dvs_neg) ? (DW'(0) - q_next) : q_next;
          remainder_d = dvd_neg ? (VW'(0) - pr_next[VW-1:0]) : pr_next[VW-1:0];
          ovf_d       = (dividend_q == {1'b1, {(DW-1){1'b0}}}) && (divisor_q == '1);
`else
          quotient_d  = q_next;
          remainder_d = pr_next[VW-1:0];
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      pr_q        <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      pr_q        <= pr_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div0      = div0_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = 1'b0;
`endif

endmodule
